code_sequencer: RTL and testbench

Program sequencer that drives the training `controller`. It owns `op`, `code_count`, `code_index` and `enable`, and reacts to the controller's `reset`, `code_reset` and `code_active` outputs. It holds a small loadable program of opcodes, one per `code_index`, where index equals layer number. It steps through the program, loops it once per epoch, and reports completion to the host side of the accelerator.

---
 rtl/code_seq_pkg.sv | 20 ++
 rtl/code_seq_if.sv | 28 ++
 rtl/code_seq_prog_mem.sv | 33 +++
 rtl/code_sequencer.sv | 165 ++++++++++++++++
 tb/tb_code_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/code_seq_pkg.sv
// code_seq_pkg
//   Shared definitions for the program sequencer and the training controller.
//   Opcode constants: OP_NOP, OP_SET_LAYER, OP_SET_COST.
//   seq_state_t: sequencer FSM states (IDLE, RUN, DONE).
//   Optional feature macro used by the sequencer: CODE_SEQ_STALL_EN.
package code_seq_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP       = 4'd0;
  localparam logic [OP_W-1:0] OP_SET_LAYER = 4'd1;
  localparam logic [OP_W-1:0] OP_SET_COST  = 4'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/code_seq_if.sv
// code_seq_if
//   Sequencer <-> controller link.
//   Sequencer drives: op, code_count, code_index, enable.
//   Controller drives: ctl_reset, ctl_code_reset, ctl_code_active.
//   Modports: master (sequencer side), slave (controller side).
interface code_seq_if #(
  parameter int OP_SIZE = 4
);

  logic [OP_SIZE-1:0] op;
  logic [31:0]        code_count;
  logic [31:0]        code_index;
  logic               enable;
  logic               ctl_reset;
  logic               ctl_code_reset;
  logic               ctl_code_active;

  modport master (
    output op, code_count, code_index, enable,
    input  ctl_reset, ctl_code_reset, ctl_code_active
  );

  modport slave (
    input  op, code_count, code_index, enable,
    output ctl_reset, ctl_code_reset, ctl_code_active
  );

endinterface

// File: rtl/code_seq_prog_mem.sv
// code_seq_prog_mem
//   PROG_DEPTH x OP_SIZE program register file.
//   Ports: clk, rst_n (async clear to all-zero), we/waddr/wdata (synchronous
//   write), raddr/rdata (asynchronous read).
module code_seq_prog_mem #(
  parameter int OP_SIZE    = 4,
  parameter int PROG_DEPTH = 8,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [OP_SIZE-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [OP_SIZE-1:0] rdata
);

  logic [OP_SIZE-1:0] mem [PROG_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/code_sequencer.sv
// code_sequencer
//   Program sequencer for the training controller. Steps through a loadable
//   opcode program (one slot per layer), loops it once per epoch and reports
//   completion to the host.
//   Host ports : start, epochs, prog_len, prog_we/prog_addr/prog_op,
//                busy, done, err, epoch_left.
//   ctl        : code_seq_if.master (op, code_count, code_index, enable out;
//                ctl_reset, ctl_code_reset, ctl_code_active in).
//   Optional   : CODE_SEQ_STALL_EN adds input stall (freezes a run in place).
module code_sequencer
  import code_seq_pkg::*;
#(
  parameter int OP_SIZE    = 4,
  parameter int PROG_DEPTH = 8,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef CODE_SEQ_STALL_EN
  input  logic               stall,
`endif
  input  logic               start,
  input  logic [31:0]        epochs,
  input  logic [AW:0]        prog_len,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [OP_SIZE-1:0] prog_op,
  code_seq_if.master         ctl,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        epoch_left
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  seq_state_t state, state_nxt;

  logic [31:0]        cnt_q, cnt_nxt;
  logic [31:0]        idx_q, idx_nxt;
  logic [31:0]        ep_q, ep_nxt;
  logic [AW:0]        len_q, len_nxt;
  logic               err_q, err_nxt;
  logic               busy_q, done_q;
  logic               stall_w;
  logic [31:0]        last_idx;
  logic [OP_SIZE-1:0] rd_op;

`ifdef CODE_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign last_idx = 32'(len_q) - 32'd1;

  code_seq_prog_mem #(
    .OP_SIZE   (OP_SIZE),
    .PROG_DEPTH(PROG_DEPTH),
    .AW        (AW)
  ) u_prog_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (prog_we && (state == IDLE)),
    .waddr(prog_addr),
    .wdata(prog_op),
    .raddr(idx_q[AW-1:0]),
    .rdata(rd_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and counter updates; RUN applies the controller responses in
  // priority order, and a stall freezes everything including the state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    ep_nxt    = ep_q;
    len_nxt   = len_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (start) begin
          len_nxt   = prog_len;
          ep_nxt    = epochs;
          err_nxt   = 1'b0;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = (epochs == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!stall_w) begin
          if (ctl.ctl_code_reset) begin
            idx_nxt = '0;
            cnt_nxt = '0;
            ep_nxt  = ep_q - 32'd1;
            if (ep_q == 32'd1) begin
              state_nxt = DONE;
            end
          end else if (ctl.ctl_reset && ctl.ctl_code_active) begin
            cnt_nxt = '0;
            // Advancing past the last slot means the program lacks an
            // epoch terminator; index holds on the last slot.
            if (idx_q == last_idx) begin
              err_nxt   = 1'b1;
              state_nxt = DONE;
            end else begin
              idx_nxt = idx_q + 32'd1;
            end
          end else if (ctl.ctl_reset) begin
            cnt_nxt = '0;
          end else begin
            cnt_nxt = sat_inc(cnt_q);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      ep_q   <= '0;
      len_q  <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      idx_q  <= idx_nxt;
      ep_q   <= ep_nxt;
      len_q  <= len_nxt;
      err_q  <= err_nxt;
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

  assign ctl.op         = busy_q ? rd_op : OP_SIZE'(OP_NOP);
  assign ctl.code_count = cnt_q;
  assign ctl.code_index = idx_q;
  assign ctl.enable     = busy_q & ~stall_w;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign epoch_left     = ep_q;

endmodule

// File: tb/tb_code_sequencer.sv
// tb_code_sequencer
//   Bench for code_sequencer with a behavioural size=3 controller stand-in
//   (set_layer 15 cycles, set_cost 3 cycles ending the epoch, nop 1 cycle).
//   Table-driven runs, randomized programs against a slot/epoch model,
//   mid-run reset, ignored writes/start during RUN, and (CODE_SEQ_STALL_EN)
//   a stall sequence.
module tb_code_sequencer;
  import code_seq_pkg::*;

  localparam int OP_SIZE    = 4;
  localparam int PROG_DEPTH = 8;
  localparam int AW         = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [31:0]        epochs = '0;
  logic [AW:0]        prog_len = '0;
  logic               prog_we = 1'b0;
  logic [AW-1:0]      prog_addr = '0;
  logic [OP_SIZE-1:0] prog_op = '0;
  logic               busy, done, err;
  logic [31:0]        epoch_left;
`ifdef CODE_SEQ_STALL_EN
  logic               stall = 1'b0;
`endif

  code_seq_if #(.OP_SIZE(OP_SIZE)) cif();

  always #5 clk = ~clk;

  code_sequencer #(
    .OP_SIZE   (OP_SIZE),
    .PROG_DEPTH(PROG_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CODE_SEQ_STALL_EN
    .stall     (stall),
`endif
    .start     (start),
    .epochs    (epochs),
    .prog_len  (prog_len),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_op   (prog_op),
    .ctl       (cif),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .epoch_left(epoch_left)
  );

  // Controller stand-in, size=3.
  always_comb begin
    cif.ctl_reset       = 1'b0;
    cif.ctl_code_reset  = 1'b0;
    cif.ctl_code_active = 1'b0;
    if (!cif.enable) begin
      cif.ctl_code_reset = 1'b1;
    end else if (cif.op == OP_NOP) begin
      cif.ctl_reset       = 1'b1;
      cif.ctl_code_active = 1'b1;
    end else if (cif.op == OP_SET_LAYER) begin
      if (cif.code_count == 32'd14) begin
        cif.ctl_reset       = 1'b1;
        cif.ctl_code_active = 1'b1;
      end
    end else if (cif.op == OP_SET_COST) begin
      if (cif.code_count == 32'd2) cif.ctl_code_reset = 1'b1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Reference model: walks slots per epoch using per-opcode durations.
  typedef struct { int idx; int cnt; int op; } step_t;
  step_t exp_q[$];
  int    m_err, m_ep, m_idx;

  task automatic build_model(input logic [31:0] prog, input int len, input int ep);
    bit ended;
    int opv, d;
    exp_q.delete();
    m_err = 0;
    m_ep  = ep;
    m_idx = 0;
    for (int e = 0; e < ep && m_err == 0; e++) begin
      ended = 1'b0;
      for (int i = 0; i < len && !ended && m_err == 0; i++) begin
        opv = int'(prog[4*i +: 4]);
        d   = (opv == 1) ? 15 : (opv == 2) ? 3 : 1;
        for (int c = 0; c < d; c++) exp_q.push_back('{i, c, opv});
        if (opv == 2) begin
          ended = 1'b1;
          m_ep--;
        end else if (i == len - 1) begin
          m_err = 1;
          m_idx = len - 1;
        end
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] prog, input int len,
                           input int ep, input bit load, input bit inject,
                           input int x_cyc, input int x_err, input int x_ep);
    int k;
    build_model(prog, len, ep);
    if (load) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = AW'(i);
        prog_op   = prog[4*i +: 4];
      end
    end
    @(negedge clk);
    prog_we  = 1'b0;
    start    = 1'b1;
    epochs   = 32'(ep);
    prog_len = (AW+1)'(len);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (busy === 1'b1 && k < 2000) begin
      if (k < exp_q.size()) begin
        chk({tag, " idx"}, 64'(cif.code_index), 64'(exp_q[k].idx));
        chk({tag, " cnt"}, 64'(cif.code_count), 64'(exp_q[k].cnt));
        chk({tag, " op"}, 64'(cif.op), 64'(exp_q[k].op));
      end
      chk({tag, " enable"}, 64'(cif.enable), 64'd1);
      if (inject && k == 5) begin
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_op   = 4'd2;
        start     = 1'b1;
        epochs    = 32'd7;
      end else begin
        prog_we = 1'b0;
        start   = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    prog_we = 1'b0;
    start   = 1'b0;
    chk({tag, " cycles"}, 64'(k), 64'(exp_q.size()));
    if (x_cyc >= 0) chk({tag, " cycles_tbl"}, 64'(k), 64'(x_cyc));
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " err"}, 64'(err), 64'(m_err));
    chk({tag, " epoch_left"}, 64'(epoch_left), 64'(m_ep));
    chk({tag, " final_idx"}, 64'(cif.code_index), 64'(m_idx));
    chk({tag, " final_cnt"}, 64'(cif.code_count), 64'd0);
    chk({tag, " idle_op"}, 64'(cif.op), 64'd0);
    if (x_err >= 0) chk({tag, " err_tbl"}, 64'(err), 64'(x_err));
    if (x_ep >= 0) chk({tag, " ep_tbl"}, 64'(epoch_left), 64'(x_ep));
    @(negedge clk);
    chk({tag, " done_1cyc"}, 64'(done), 64'd0);
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " enable"}, 64'(cif.enable), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " err"}, 64'(err), 64'd0);
    chk({tag, " epoch_left"}, 64'(epoch_left), 64'd0);
    chk({tag, " code_index"}, 64'(cif.code_index), 64'd0);
    chk({tag, " code_count"}, 64'(cif.code_count), 64'd0);
    chk({tag, " op"}, 64'(cif.op), 64'd0);
  endtask

  typedef struct {
    logic [31:0] prog;
    int          len;
    int          ep;
    int          cyc;
    int          err;
    int          ep_left;
  } vec_t;

  vec_t vt[7];

  initial begin
    int len, ep, k;
    logic [31:0] prog;

    vt[0] = '{32'h0000_0211, 3, 2, 66, 0, 0};
    vt[1] = '{32'h0000_0211, 3, 0, 0, 0, 0};
    vt[2] = '{32'h0000_0011, 2, 3, 30, 1, 3};
    vt[3] = '{32'h0000_0200, 3, 1, 5, 0, 0};
    vt[4] = '{32'h0000_0002, 1, 4, 12, 0, 0};
    vt[5] = '{32'h0000_0021, 4, 2, 36, 0, 0};
    vt[6] = '{32'h0000_0000, 8, 1, 8, 1, 1};

    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_check($sformatf("vec%0d", i), vt[i].prog, vt[i].len, vt[i].ep, 1'b1, 1'b0,
                vt[i].cyc, vt[i].err, vt[i].ep_left);
    end

    // prog_we and start during RUN are dropped; run length unchanged.
    run_check("inject", 32'h0000_0211, 3, 2, 1'b1, 1'b1, 66, 0, 0);

    // Mid-run reset at code_count 7.
    for (int i = 0; i < PROG_DEPTH; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_op   = (i < 2) ? 4'd1 : (i == 2) ? 4'd2 : 4'd0;
    end
    @(negedge clk);
    prog_we  = 1'b0;
    start    = 1'b1;
    epochs   = 32'd2;
    prog_len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (cif.code_count != 32'd7 && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk("midrst reach", 64'(k), 64'd7);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    // Unloaded program must read back as all no-ops.
    run_check("cleared", 32'h0, 3, 1, 1'b0, 1'b0, 3, 1, 1);

    for (int r = 0; r < 20; r++) begin
      len  = int'($urandom_range(1, 8));
      ep   = int'($urandom_range(0, 3));
      prog = '0;
      for (int i = 0; i < len; i++) prog[4*i +: 4] = 4'($urandom_range(0, 2));
      run_check($sformatf("rnd%0d", r), prog, len, ep, 1'b1, 1'b0, -1, -1, -1);
    end

`ifdef CODE_SEQ_STALL_EN
    for (int i = 0; i < PROG_DEPTH; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_op   = (i < 2) ? 4'd1 : (i == 2) ? 4'd2 : 4'd0;
    end
    @(negedge clk);
    prog_we  = 1'b0;
    start    = 1'b1;
    epochs   = 32'd1;
    prog_len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (busy === 1'b1 && cif.code_count != 32'd4 && k < 100) begin
      k++;
      @(negedge clk);
    end
    stall = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      chk("stall enable", 64'(cif.enable), 64'd0);
      chk("stall cnt", 64'(cif.code_count), 64'd4);
      chk("stall busy", 64'(busy), 64'd1);
      k++;
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("resume enable", 64'(cif.enable), 64'd1);
    chk("resume cnt", 64'(cif.code_count), 64'd4);
    while (busy === 1'b1 && k < 500) begin
      k++;
      @(negedge clk);
    end
    chk("stall total", 64'(k), 64'd38);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
